// File: rtl/debug_cmd_ctrl_pkg.sv
// Shared definitions for the debug command controller: command codes,
// FSM state encoding, read-source select and the byte-select helper.
package debug_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_REGS = 8'h47;
    localparam logic [7:0] CMD_MEM  = 8'h4D;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_POP      = 4'd1,
        ST_DECODE   = 4'd2,
        ST_ARG_WAIT = 4'd3,
        ST_ARG_POP  = 4'd4,
        ST_STEP     = 4'd5,
        ST_RUN      = 4'd6,
        ST_LOAD     = 4'd7,
        ST_SEND     = 4'd8,
        ST_NEXT     = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        SRC_PC  = 2'd0,
        SRC_REG = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    // Byte n (1-based, counted from the LSB) of a 32-bit word
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] n);
        case (n)
            3'd1:    byte_of = w[7:0];
            3'd2:    byte_of = w[15:8];
            3'd3:    byte_of = w[23:16];
            3'd4:    byte_of = w[31:24];
            default: byte_of = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/debug_cmd_ctrl_byte_tx.sv
// MSB-first serializer of a 1..4 byte reply into the TX FIFO. A push is
// followed by one idle cycle so the FIFO full flag has settled before the next.
module debug_cmd_ctrl_byte_tx
    import debug_cmd_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [2:0]  nbytes,
    input  logic        tx_full,
    output logic        wr,
    output logic [7:0]  w_data,
    output logic        done
);

    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gap_q, gap_d;
    logic        wr_q, wr_d;
    logic [7:0]  w_data_q, w_data_d;
    logic        done_q, done_d;

    // Next-state: capture a new reply or emit the next byte when the FIFO has room
    always_comb begin
        word_d   = word_q;
        cnt_d    = cnt_q;
        gap_d    = 1'b0;
        wr_d     = 1'b0;
        w_data_d = w_data_q;
        done_d   = 1'b0;
        if (load) begin
            word_d = word;
            cnt_d  = nbytes;
        end else if (cnt_q != 3'd0 && !gap_q && !tx_full) begin
            wr_d     = 1'b1;
            w_data_d = byte_of(word_q, cnt_q);
            cnt_d    = cnt_q - 3'd1;
            gap_d    = 1'b1;
            done_d   = (cnt_q == 3'd1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Serializer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q   <= 32'h0000_0000;
            cnt_q    <= 3'd0;
            gap_q    <= 1'b0;
            wr_q     <= 1'b0;
            w_data_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            wr_q     <= wr_d;
            w_data_q <= w_data_d;
            done_q   <= done_d;
        end
    end

    assign wr     = wr_q;
    assign w_data = w_data_q;
    assign done   = done_q;

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Debug command sequencer: pops UART command bytes, steps/runs the core and
// returns PC, register or memory words MSB-first through the TX FIFO.
module debug_cmd_ctrl
    import debug_cmd_ctrl_pkg::*;
#(
    parameter int MEM_AW = 8,
    parameter int RUN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rd,
    input  logic              tx_full,
    output logic              wr,
    output logic [7:0]        w_data,
    output logic              cpu_en,
    input  logic              halted,
    input  logic [31:0]       pc,
    output logic [4:0]        reg_addr,
    input  logic [31:0]       reg_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    src_e              src_q, src_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       word_q, word_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic              load_q, load_d;
    logic              load_wait_q, load_wait_d;
    logic              rd_q, rd_d;
    logic              tx_done_s;

    // Command sequencing and next-state computation
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        src_d       = src_q;
        run_cnt_d   = run_cnt_q;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        word_d      = word_q;
        nbytes_d    = nbytes_q;
        load_d      = 1'b0;
        load_wait_d = load_wait_q;
        rd_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_empty) begin
                    rd_d    = 1'b1;
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                cmd_d   = rx_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (cmd_q)
                    CMD_STEP: state_d = ST_STEP;
                    CMD_RUN: begin
                        run_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                    CMD_REGS: begin
                        reg_addr_d  = 5'd0;
                        src_d       = SRC_REG;
                        load_wait_d = 1'b0;
                        state_d     = ST_LOAD;
                    end
                    CMD_MEM: state_d = ST_ARG_WAIT;
                    default: begin
                        // src must not stay REG or NEXT would resume a dump
                        src_d    = SRC_PC;
                        word_d   = {24'h00_0000, RSP_ERR};
                        nbytes_d = 3'd1;
                        load_d   = 1'b1;
                        state_d  = ST_SEND;
                    end
                endcase
            end
            ST_ARG_WAIT: begin
                if (!rx_empty) begin
                    rd_d    = 1'b1;
                    state_d = ST_ARG_POP;
                end else begin
                    state_d = ST_ARG_WAIT;
                end
            end
            ST_ARG_POP: begin
                mem_addr_d  = MEM_AW'(rx_data);
                src_d       = SRC_MEM;
                load_wait_d = 1'b0;
                state_d     = ST_LOAD;
            end
            ST_STEP: begin
                src_d       = SRC_PC;
                load_wait_d = 1'b0;
                state_d     = ST_LOAD;
            end
            ST_RUN: begin
                if (halted || run_cnt_q == RUN_MAX) begin
                    src_d       = SRC_PC;
                    load_wait_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end
            ST_LOAD: begin
                // first cycle lets the synchronous read ports settle
                if (!load_wait_q) begin
                    load_wait_d = 1'b1;
                end else begin
                    load_wait_d = 1'b0;
                    case (src_q)
                        SRC_REG: word_d = reg_rdata;
                        SRC_MEM: word_d = mem_rdata;
                        default: word_d = pc;
                    endcase
                    nbytes_d = 3'd4;
                    load_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_done_s) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_NEXT: begin
                if (src_q == SRC_REG && reg_addr_q != 5'd31) begin
                    reg_addr_d  = reg_addr_q + 5'd1;
                    load_wait_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            src_q       <= SRC_PC;
            run_cnt_q   <= '0;
            reg_addr_q  <= 5'd0;
            mem_addr_q  <= '0;
            word_q      <= 32'h0000_0000;
            nbytes_q    <= 3'd0;
            load_q      <= 1'b0;
            load_wait_q <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            src_q       <= src_d;
            run_cnt_q   <= run_cnt_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            word_q      <= word_d;
            nbytes_q    <= nbytes_d;
            load_q      <= load_d;
            load_wait_q <= load_wait_d;
            rd_q        <= rd_d;
        end
    end

    debug_cmd_ctrl_byte_tx u_byte_tx (
        .clk     (clk),
        .reset   (reset),
        .load    (load_q),
        .word    (word_q),
        .nbytes  (nbytes_q),
        .tx_full (tx_full),
        .wr      (wr),
        .w_data  (w_data),
        .done    (tx_done_s)
    );

    // halted must cut the enable in the very cycle it rises
    assign cpu_en   = (state_q == ST_STEP) ||
                      (state_q == ST_RUN && !halted && run_cnt_q != RUN_MAX);
    assign rd       = rd_q;
    assign reg_addr = reg_addr_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Randomized and directed bench for debug_cmd_ctrl: RX/TX FIFO and core models
// plus a command-level reference that predicts reply bytes, PC and enabled cycles.
module tb_debug_cmd_ctrl;

    localparam int MEM_AW   = 8;
    localparam int RUN_W    = 4;
    localparam int RUN_MAX  = (1 << RUN_W) - 1;
    localparam int TX_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_empty = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rd;
    logic              tx_full = 1'b0;
    logic              wr;
    logic [7:0]        w_data;
    logic              cpu_en;
    logic              halted = 1'b0;
    logic [31:0]       pc = 32'h0;
    logic [4:0]        reg_addr;
    logic [31:0]       reg_rdata = 32'h0;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata = 32'h0;

    always #5 clk = ~clk;

    debug_cmd_ctrl #(.MEM_AW(MEM_AW), .RUN_W(RUN_W)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rd(rd),
        .tx_full(tx_full), .wr(wr), .w_data(w_data), .cpu_en(cpu_en), .halted(halted),
        .pc(pc), .reg_addr(reg_addr), .reg_rdata(reg_rdata), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    logic [31:0] regs[32];
    logic [31:0] mem[256];
    int          checks = 0, errors = 0;
    logic [31:0] e_pc = 32'h0, m_pc = 32'h0;
    int          e_budget = 0, m_budget = 0, e_en = 0, m_en = 0, rd_cnt = 0, occ = 0;
    bit          pop_pend = 1'b0, force_full = 1'b0, rand_full = 1'b0, arg_pending = 1'b0;
    logic [4:0]  ra_d1 = 5'd0;
    logic [MEM_AW-1:0] ma_d1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of environment: FIFOs, core, read ports, and the per-cycle compare
    task automatic tick();
        @(negedge clk);
        if (pop_pend) void'(rx_q.pop_front());
        pop_pend = 1'b0;
        if (rd) begin
            rd_cnt++;
            check("rd_when_nonempty", 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) pop_pend = 1'b1;
        end
        if (wr) begin
            check("wr_when_not_full", 32'(tx_full), 32'd0);
            check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("tx_byte", 32'(w_data), 32'(exp_q.pop_front()));
            log_q.push_back(w_data);
            occ++;
        end
        if (cpu_en) begin
            e_en++;
            if (e_budget > 0) begin
                e_pc = e_pc + 32'd4;
                e_budget--;
            end
        end
        reg_rdata = regs[ra_d1];
        ra_d1     = reg_addr;
        mem_rdata = mem[ma_d1];
        ma_d1     = mem_addr;
        if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
        tx_full  = force_full || (rand_full && $urandom_range(0, 3) == 0) || (occ >= TX_DEPTH);
        halted   = (e_budget == 0);
        pc       = e_pc;
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    endtask

    // Reference: queue a byte and predict its whole effect at the command level
    task automatic rx_push(input logic [7:0] b);
        int n;
        rx_q.push_back(b);
        if (arg_pending) begin
            push_word(mem[b], 4);
            arg_pending = 1'b0;
        end else begin
            case (b)
                8'h53: begin
                    m_en++;
                    if (m_budget > 0) begin
                        m_pc = m_pc + 32'd4;
                        m_budget--;
                    end
                    push_word(m_pc, 4);
                end
                8'h52: begin
                    n = (m_budget < RUN_MAX) ? m_budget : RUN_MAX;
                    m_en += n;
                    m_pc = m_pc + 32'(4 * n);
                    m_budget -= n;
                    push_word(m_pc, 4);
                end
                8'h47: for (int i = 0; i < 32; i++) push_word(regs[i], 4);
                8'h4D: arg_pending = 1'b1;
                default: push_word({24'h0, 8'h3F}, 1);
            endcase
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check({name, "_timeout"}, 32'(t < 3000), 32'd1);
        repeat (8) tick();
        check({name, "_cpu_en_cycles"}, 32'(e_en), 32'(m_en));
        check({name, "_pc"}, e_pc, m_pc);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_rd"}, 32'(rd), 32'd0);
        check({name, "_wr"}, 32'(wr), 32'd0);
        check({name, "_w_data"}, 32'(w_data), 32'd0);
        check({name, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({name, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    function automatic logic [31:0] log_word(input int i);
        return {log_q[i], log_q[i+1], log_q[i+2], log_q[i+3]};
    endfunction

    function automatic logic [31:0] exp_word(input int i);
        return {exp_q[i], exp_q[i+1], exp_q[i+2], exp_q[i+3]};
    endfunction

    initial begin
        int en0, rd0, t, k;
        logic [7:0] b;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'hDEAD_BEEF;

        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        e_pc = 32'h0040_0000; m_pc = 32'h0040_0000;
        e_budget = 1000; m_budget = 1000;
        tick();

        // single step
        en0 = e_en; rd0 = rd_cnt; log_q.delete();
        rx_push(8'h53);
        check("model_step_bytes", exp_word(0), 32'h0040_0004);
        drain("step");
        check("step_en_cycles", 32'(e_en - en0), 32'd1);
        check("step_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("step_reply", log_word(0), 32'h0040_0004);

        // run stopped by halt after 10 instructions
        e_pc = 32'h0; m_pc = 32'h0; e_budget = 10; m_budget = 10;
        tick();
        en0 = e_en; log_q.delete();
        rx_push(8'h52);
        check("model_run_pc", m_pc, 32'h0000_0028);
        drain("run_halt");
        check("run_halt_en_cycles", 32'(e_en - en0), 32'd10);
        check("run_halt_reply", log_word(0), 32'h0000_0028);

        // halted already set: zero cycles run
        en0 = e_en; log_q.delete();
        rx_push(8'h52);
        drain("run_halted");
        check("run_halted_en_cycles", 32'(e_en - en0), 32'd0);

        // run stopped by timeout
        e_budget = 100000; m_budget = 100000;
        tick();
        en0 = e_en; log_q.delete();
        rx_push(8'h52);
        drain("run_timeout");
        check("run_timeout_en_cycles", 32'(e_en - en0), 32'd15);

        // register dump
        log_q.delete();
        rx_push(8'h47);
        drain("regs");
        check("regs_byte_count", 32'(log_q.size()), 32'd128);
        check("regs_word1", log_word(4), 32'h0101_0101);
        check("regs_word31", log_word(124), 32'h1F1F_1F1F);

        // memory read with a late argument byte
        log_q.delete(); rd0 = rd_cnt;
        rx_push(8'h4D);
        repeat (20) tick();
        check("mem_arg_wait_rd", 32'(rd_cnt - rd0), 32'd1);
        check("mem_arg_wait_tx", 32'(log_q.size()), 32'd0);
        rx_push(8'h05);
        drain("mem");
        check("mem_reply", log_word(0), 32'hDEAD_BEEF);

        // unknown command against a full TX FIFO
        log_q.delete(); force_full = 1'b1;
        rx_push(8'h99);
        repeat (8) tick();
        check("err_held_while_full", 32'(log_q.size()), 32'd0);
        force_full = 1'b0;
        drain("err");
        check("err_byte_count", 32'(log_q.size()), 32'd1);
        check("err_byte", 32'(log_q[0]), 32'h3F);

        // reset in the middle of a dump; the queued step survives it
        log_q.delete();
        rx_push(8'h47);
        rx_push(8'h53);
        t = 0;
        while (log_q.size() < 40 && t < 2000) begin
            tick();
            t++;
        end
        check("reset_mid_send_reached", 32'(t < 2000), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        check_outputs_zero("reset_mid_send");
        while (exp_q.size() > 4) void'(exp_q.pop_front());
        @(posedge clk); #1;
        reset = 1'b0;
        drain("after_reset");

        // randomized command mix with random TX backpressure
        rand_full = 1'b1;
        for (int batch = 0; batch < 6; batch++) begin
            k = $urandom_range(0, 20);
            e_budget = (k > 17) ? 100000 : k;
            m_budget = e_budget;
            tick();
            for (int c = 0; c < 6; c++) begin
                k = $urandom_range(0, 9);
                if (k <= 2 || (k == 9 && c != 0)) begin
                    rx_push(8'h53);
                end else if (k <= 4) begin
                    rx_push(8'h52);
                end else if (k <= 6) begin
                    rx_push(8'h4D);
                    repeat ($urandom_range(0, 6)) tick();
                    rx_push(8'($urandom_range(0, 255)));
                end else if (k <= 8) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h53 || b == 8'h52 || b == 8'h47 || b == 8'h4D) b = 8'h00;
                    rx_push(b);
                end else begin
                    rx_push(8'h47);
                end
                repeat ($urandom_range(0, 15)) tick();
            end
            drain("random");
        end
        rand_full = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
